// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types and constants for the data-cache miss controller.
package dcache_miss_ctrl_pkg;

  localparam int unsigned WORDS_PER_BLOCK_DEF = 8;
  localparam int unsigned MEM_LATENCY_DEF     = 4;
  localparam int unsigned BLOCK_OFFSET_W      = 4;
  localparam int unsigned ADDR_W              = 16;
  localparam int unsigned WORD_IDX_W          = 3;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [WORD_IDX_W-1:0] word_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Main-memory request as driven onto the bus.
  typedef struct packed {
    logic  en;
    logic  wr;
    addr_t addr;
  } mem_req_t;

  // Halfword-aligned address of word `idx` inside the block holding `a`.
  function automatic addr_t fill_addr(addr_t a, word_idx_t idx);
    return {a[ADDR_W-1:BLOCK_OFFSET_W], idx, 1'b0};
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// Pipeline/memory-side signal bundle of the miss controller.
interface dcache_miss_ctrl_if;

  logic                           M_MemRead;
  logic                           M_MemWrite;
  dcache_miss_ctrl_pkg::addr_t    M_Addr;
  logic                           hit;
  logic                           mem_data_valid;
  logic                           mem_en;
  logic                           mem_wr;
  dcache_miss_ctrl_pkg::addr_t    mem_addr;
  logic                           fill_wen;
  dcache_miss_ctrl_pkg::word_idx_t fill_word;
  logic                           tag_wen;
  logic                           stall;

  // Environment side: pipeline, tag compare and main memory.
  modport master (
    output M_MemRead, M_MemWrite, M_Addr, hit, mem_data_valid,
    input  mem_en, mem_wr, mem_addr, fill_wen, fill_word, tag_wen, stall
  );

  // Controller side.
  modport slave (
    input  M_MemRead, M_MemWrite, M_Addr, hit, mem_data_valid,
    output mem_en, mem_wr, mem_addr, fill_wen, fill_word, tag_wen, stall
  );

endinterface

// File: rtl/dcache_miss_ctrl_fill_counter.sv
// Enable-gated up-counter with synchronous clear and async active-low reset.
module fill_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wen,
  output logic [WIDTH-1:0] cnt_q
);

  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wen) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: stalls on a miss, streams an 8-word block fill
// from pipelined memory, and issues write-through requests for store hits.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int unsigned MEM_LATENCY     = MEM_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  dcache_miss_ctrl_if.slave bus
);

  localparam int unsigned RECV_W  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned ISSUE_W = RECV_W + 1;

  // The word index port is fixed at 3 bits, so the block must hold 8 words.
  if (WORDS_PER_BLOCK != (1 << WORD_IDX_W) || MEM_LATENCY == 0) begin : g_cfg_check
    $error("dcache_miss_ctrl: unsupported WORDS_PER_BLOCK/MEM_LATENCY");
  end

  state_e              state_q, state_d;
  logic [ISSUE_W-1:0]  issue_cnt;
  logic [RECV_W-1:0]   recv_cnt;
  logic                cnt_clr_c;
  logic                issue_en_c;
  logic                recv_en_c;
  logic                miss_c;
  logic                store_hit_c;
  mem_req_t            req_c;

  assign miss_c      = (bus.M_MemRead | bus.M_MemWrite) & ~bus.hit;
  assign store_hit_c = bus.M_MemWrite & bus.hit;

  always_comb begin
    state_d       = state_q;
    cnt_clr_c     = 1'b0;
    issue_en_c    = 1'b0;
    recv_en_c     = 1'b0;
    req_c         = '0;
    bus.stall     = 1'b0;
    bus.fill_wen  = 1'b0;
    bus.fill_word = '0;
    bus.tag_wen   = 1'b0;

    case (state_q)
      IDLE: begin
        bus.stall = miss_c;
        if (miss_c) begin
          state_d   = FILL;
          cnt_clr_c = 1'b1;
        end else if (store_hit_c) begin
          req_c = '{en: 1'b1, wr: 1'b1, addr: bus.M_Addr};
        end
      end

      FILL: begin
        bus.stall = 1'b1;
        // Request issue and data return run independently in the same cycle.
        if (issue_cnt < ISSUE_W'(WORDS_PER_BLOCK)) begin
          issue_en_c = 1'b1;
          req_c      = '{en: 1'b1, wr: 1'b0,
                         addr: fill_addr(bus.M_Addr, issue_cnt[RECV_W-1:0])};
        end
        if (bus.mem_data_valid) begin
          recv_en_c     = 1'b1;
          bus.fill_wen  = 1'b1;
          bus.fill_word = recv_cnt;
          if (recv_cnt == RECV_W'(WORDS_PER_BLOCK - 1)) begin
            bus.tag_wen = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_en   = req_c.en;
  assign bus.mem_wr   = req_c.wr;
  assign bus.mem_addr = req_c.addr;

  fill_counter #(.WIDTH(ISSUE_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_c),
    .wen   (issue_en_c),
    .cnt_q (issue_cnt)
  );

  fill_counter #(.WIDTH(RECV_W)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_c),
    .wen   (recv_en_c),
    .cnt_q (recv_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
